// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use stall, branch flush and mul/div freeze sequencing for
//            the 5-stage pipeline. Optional macro HAZARD_PERF_EN adds
//            saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX_memread,
    input  logic [4:0] ID_EX_wr_reg,
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    input  logic       IF_ID_use_rs1,
    input  logic       IF_ID_use_rs2,
    input  logic       ID_EX_muldiv,
    input  logic       md_done,
    input  logic       branch_taken,
    output logic       md_start,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_bubble,
    output logic       EX_MEM_bubble,
    output logic       md_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_loaduse_cnt,
    output logic [31:0] perf_md_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             md_expire;
    logic             loaduse_stall;

    assign load_use = ID_EX_memread && (ID_EX_wr_reg != 5'd0) &&
                      ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_wr_reg)) ||
                       (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_wr_reg)));

    assign md_expire = (md_cnt == CNT_W'(MD_TIMEOUT - 1));

    assign loaduse_stall = !rst && (state == RUN) && !branch_taken &&
                           !ID_EX_muldiv && load_use;

    // Outputs are forced to pass-through values while rst is held.
    always_comb begin
        md_start      = 1'b0;
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        ID_EX_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        if (!rst) begin
            if (state == RUN) begin
                if (branch_taken) begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                end else if (ID_EX_muldiv) begin
                    md_start      = 1'b1;
                    pc_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    ID_EX_write   = 1'b0;
                    EX_MEM_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                end
            end else if (!md_done && !md_expire) begin
                pc_write      = 1'b0;
                IF_ID_write   = 1'b0;
                ID_EX_write   = 1'b0;
                EX_MEM_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (!branch_taken && ID_EX_muldiv) begin
                state  <= MD_BUSY;
                md_cnt <= '0;
            end
        end else begin
            if (md_done) begin
                state <= RUN;
            end else if (md_expire) begin
                state      <= RUN;
                md_timeout <= 1'b1;
            end else begin
                md_cnt <= md_cnt + 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loaduse_cnt <= '0;
            perf_md_cnt      <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (loaduse_stall && (perf_loaduse_cnt != '1))
                perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
            if (EX_MEM_bubble && (perf_md_cnt != '1))
                perf_md_cnt <= perf_md_cnt + 32'd1;
            if (IF_ID_flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = loaduse_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed plus randomized checking of hazard_stall_ctrl against a
//            cycle-indexed behavioural model of the pipeline control rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ID_EX_memread = 1'b0;
    logic [4:0] ID_EX_wr_reg = '0;
    logic [4:0] IF_ID_rs1 = '0;
    logic [4:0] IF_ID_rs2 = '0;
    logic       IF_ID_use_rs1 = 1'b0;
    logic       IF_ID_use_rs2 = 1'b0;
    logic       ID_EX_muldiv = 1'b0;
    logic       md_done = 1'b0;
    logic       branch_taken = 1'b0;
    logic       md_start, pc_write, IF_ID_write, ID_EX_write;
    logic       IF_ID_flush, ID_EX_bubble, EX_MEM_bubble, md_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // model: whether a mul/div is outstanding, the cycle it launched, sticky timeout
    bit m_busy = 1'b0;
    bit m_tmo  = 1'b0;
    int m_launch = 0;
    int cyc = 0;

    hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_memread(ID_EX_memread), .ID_EX_wr_reg(ID_EX_wr_reg),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_muldiv(ID_EX_muldiv), .md_done(md_done), .branch_taken(branch_taken),
        .md_start(md_start), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .ID_EX_write(ID_EX_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .EX_MEM_bubble(EX_MEM_bubble),
        .md_timeout(md_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_in(input bit mr, input int wr, input int r1, input int r2,
                          input bit u1, input bit u2, input bit md, input bit dn,
                          input bit br);
        ID_EX_memread = mr;
        ID_EX_wr_reg  = 5'(wr);
        IF_ID_rs1     = 5'(r1);
        IF_ID_rs2     = 5'(r2);
        IF_ID_use_rs1 = u1;
        IF_ID_use_rs2 = u2;
        ID_EX_muldiv  = md;
        md_done       = dn;
        branch_taken  = br;
    endtask

    // Predict this cycle's outputs from the model, compare, then advance one clock.
    task automatic step();
        bit hz, frz, e_start, e_pcw, e_stall_id, e_flush, e_idb, e_exb;
        hz = ID_EX_memread && (ID_EX_wr_reg != 0) &&
             ((IF_ID_use_rs1 && IF_ID_rs1 == ID_EX_wr_reg) ||
              (IF_ID_use_rs2 && IF_ID_rs2 == ID_EX_wr_reg));
        frz = 0; e_start = 0; e_stall_id = 0; e_flush = 0; e_idb = 0; e_exb = 0;
        if (!rst) begin
            if (m_busy) begin
                if (!md_done && (cyc - m_launch) < MD_TIMEOUT) begin
                    frz = 1; e_exb = 1;
                end
            end else if (branch_taken) begin
                e_flush = 1; e_idb = 1;
            end else if (ID_EX_muldiv) begin
                e_start = 1; frz = 1; e_exb = 1;
            end else if (hz) begin
                e_stall_id = 1; e_idb = 1;
            end
        end
        e_pcw = !(frz || e_stall_id);
        @(negedge clk);
        check("md_start",      md_start,      e_start);
        check("pc_write",      pc_write,      e_pcw);
        check("IF_ID_write",   IF_ID_write,   e_pcw);
        check("ID_EX_write",   ID_EX_write,   !frz);
        check("IF_ID_flush",   IF_ID_flush,   e_flush);
        check("ID_EX_bubble",  ID_EX_bubble,  e_idb);
        check("EX_MEM_bubble", EX_MEM_bubble, e_exb);
        check("md_timeout",    md_timeout,    rst ? 1'b0 : m_tmo);
        @(posedge clk);
        if (rst) begin
            m_busy = 0;
            m_tmo  = 0;
        end else if (m_busy) begin
            if (md_done || (cyc - m_launch) >= MD_TIMEOUT) begin
                if (!md_done) m_tmo = 1;
                m_busy = 0;
            end
        end else if (!branch_taken && ID_EX_muldiv) begin
            m_busy   = 1;
            m_launch = cyc;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int stall_cnt;
        // reset holds pass-through outputs even with a branch on the inputs
        rst = 1'b1;
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // load-use on rs1, then self-terminated by bubble
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); step();
        set_in(0, 5, 5, 0, 1, 0, 0, 0, 0); step();
        // x0 destination and unused rs2
        set_in(1, 0, 0, 0, 1, 1, 0, 0, 0); step();
        set_in(1, 7, 1, 7, 1, 0, 0, 0, 0); step();
        // load-use on rs2
        set_in(1, 9, 1, 9, 0, 1, 0, 0, 0); step();

        // 4-cycle mul/div: count stall cycles independently of the model
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, (i < 4), (i == 4), 0);
            #1;
            if (!pc_write) stall_cnt++;
            step();
        end
        check("md_stall_cycles", stall_cnt, 4);
        // back-to-back launch after a 2-cycle op
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();

        // branch beats simultaneous load-use and illegal muldiv
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 1); step();
        set_in(1, 5, 5, 0, 1, 0, 1, 0, 1); step();
        // md_done in RUN is ignored
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();

        // reset two cycles into MD_BUSY, later done ignored
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step(); step(); step();
        rst = 1'b1; step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // timeout: done never arrives
        stall_cnt = 0;
        for (int i = 0; i < MD_TIMEOUT + 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, (i <= MD_TIMEOUT), 0, 0);
            #1;
            if (!pc_write && i <= MD_TIMEOUT) stall_cnt++;
            step();
        end
        check("timeout_frozen_cycles", stall_cnt, MD_TIMEOUT);
        check("timeout_sticky", md_timeout, 1'b1);

        for (int i = 0; i < 400; i++) begin
            set_in($urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
                   $urandom % 2, $urandom % 2, ($urandom % 8) == 0,
                   ($urandom % 6) == 0, ($urandom % 10) == 0);
            rst = (($urandom % 100) == 0);
            step();
        end
        rst = 1'b1; step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
